// File: rtl/vga_scan_controller.sv
// VGA 640x480@60 scan-out: 25 MHz pixel timing from the 50 MHz clock, a 256x256
// video RAM window with border fill, and a 3-stage registered pin pipeline.
module vga_scan_controller #(
  parameter int unsigned WIN_X0       = 192,
  parameter int unsigned WIN_Y0       = 112,
  parameter logic [2:0]  BORDER_COLOR = 3'b000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oReadAddress,
  input  logic [2:0]  iReadData,
  output logic        oVGA_RED,
  output logic        oVGA_GREEN,
  output logic        oVGA_BLUE,
  output logic        oVGA_HSYNC,
  output logic        oVGA_VSYNC,
  output logic        oFrameStart
);

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_LAST       = 10'd524;

  localparam logic [10:0] X_LO  = 11'(WIN_X0);
  localparam logic [10:0] X_HI  = 11'(WIN_X0 + 255);
  localparam logic [10:0] Y_LO  = 11'(WIN_Y0);
  localparam logic [10:0] Y_HI  = 11'(WIN_Y0 + 255);
  localparam logic [7:0]  X_OFF = 8'(WIN_X0);
  localparam logic [7:0]  Y_OFF = 8'(WIN_Y0);

  logic [9:0] rCol;
  logic [9:0] rRow;
  logic       rPixelEn;

  logic       wInside;
  logic       wVisible;
  logic       wHSync;
  logic       wVSync;
  logic [7:0] wColOff;
  logic [7:0] wRowOff;

  logic s1Inside, s1Visible, s1HSync, s1VSync;
  logic s2Inside, s2Visible, s2HSync, s2VSync;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rPixelEn <= 1'b0;
      rCol     <= '0;
      rRow     <= '0;
    end else begin
      rPixelEn <= ~rPixelEn;
      if (rPixelEn) begin
        if (rCol == H_LAST) begin
          rCol <= '0;
          rRow <= (rRow == V_LAST) ? '0 : rRow + 10'd1;
        end else begin
          rCol <= rCol + 10'd1;
        end
      end
    end
  end

  // Offsets wrap modulo 256, so only the low counter bits matter here.
  always_comb begin
    wColOff  = rCol[7:0] - X_OFF;
    wRowOff  = rRow[7:0] - Y_OFF;
    wInside  = ({1'b0, rCol} >= X_LO) && ({1'b0, rCol} <= X_HI) &&
               ({1'b0, rRow} >= Y_LO) && ({1'b0, rRow} <= Y_HI);
    wVisible = (rCol < H_VISIBLE) && (rRow < V_VISIBLE);
    wHSync   = !((rCol >= H_SYNC_START) && (rCol < H_SYNC_END));
    wVSync   = !((rRow >= V_SYNC_START) && (rRow < V_SYNC_END));
  end

  always_comb begin
    oFrameStart = rPixelEn && (rCol == '0) && (rRow == '0);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oReadAddress <= '0;
      s1Inside     <= 1'b0;
      s1Visible    <= 1'b0;
      s1HSync      <= 1'b1;
      s1VSync      <= 1'b1;
      s2Inside     <= 1'b0;
      s2Visible    <= 1'b0;
      s2HSync      <= 1'b1;
      s2VSync      <= 1'b1;
      oVGA_RED     <= 1'b0;
      oVGA_GREEN   <= 1'b0;
      oVGA_BLUE    <= 1'b0;
      oVGA_HSYNC   <= 1'b1;
      oVGA_VSYNC   <= 1'b1;
    end else begin
      oReadAddress <= {wRowOff, wColOff};
      s1Inside     <= wInside;
      s1Visible    <= wVisible;
      s1HSync      <= wHSync;
      s1VSync      <= wVSync;
      s2Inside     <= s1Inside;
      s2Visible    <= s1Visible;
      s2HSync      <= s1HSync;
      s2VSync      <= s1VSync;
      // RAM data for the S1 address is on iReadData while the flags sit in S2.
      if (s2Inside) begin
        {oVGA_RED, oVGA_GREEN, oVGA_BLUE} <= iReadData;
      end else if (s2Visible) begin
        {oVGA_RED, oVGA_GREEN, oVGA_BLUE} <= BORDER_COLOR;
      end else begin
        {oVGA_RED, oVGA_GREEN, oVGA_BLUE} <= 3'b000;
      end
      oVGA_HSYNC <= s2HSync;
      oVGA_VSYNC <= s2VSync;
    end
  end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed self-checking bench for vga_scan_controller: reset, sync timing,
// window mapping, border/blanking colours and mid-frame reset.
module tb_vga_scan_controller;

  logic        Clock;
  logic        Reset;
  logic [15:0] oReadAddress;
  logic [2:0]  iReadData;
  logic        oVGA_RED, oVGA_GREEN, oVGA_BLUE;
  logic        oVGA_HSYNC, oVGA_VSYNC, oFrameStart;
  logic [2:0]  ramQ;
  logic [9:0]  jRow, jCol;

  int checks = 0;
  int errors = 0;

  vga_scan_controller #(
    .WIN_X0(192),
    .WIN_Y0(112),
    .BORDER_COLOR(3'b101)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .oReadAddress(oReadAddress),
    .iReadData(iReadData),
    .oVGA_RED(oVGA_RED),
    .oVGA_GREEN(oVGA_GREEN),
    .oVGA_BLUE(oVGA_BLUE),
    .oVGA_HSYNC(oVGA_HSYNC),
    .oVGA_VSYNC(oVGA_VSYNC),
    .oFrameStart(oFrameStart)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Video RAM model: 1-clock read latency, data = {addr[8], addr[0], addr[15]}.
  always @(posedge Clock) ramQ <= {oReadAddress[8], oReadAddress[0], oReadAddress[15]};
  assign iReadData = ramQ;

  task tick;
    @(posedge Clock);
    #1;
  endtask

  // Preload the counters at a clock where rPixelEn = 0, so the pixel lasts 2 clocks.
  task jumpTo(input int r, input int c);
    int tries;
    tries = 0;
    jRow = 10'(r);
    jCol = 10'(c);
    @(negedge Clock);
    while (dut.rPixelEn !== 1'b0 && tries < 4) begin
      @(negedge Clock);
      tries++;
    end
    checks++;
    if (dut.rPixelEn !== 1'b0) begin
      errors++;
      $display("FAIL jump_phase: got rPixelEn=%b required 0", dut.rPixelEn);
    end
    force dut.rRow = jRow;
    force dut.rCol = jCol;
    release dut.rRow;
    release dut.rCol;
  endtask

  task test_reset;
    Reset = 1'b0;
    repeat (5) tick;
    checks++; if (oVGA_HSYNC !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b required 1", oVGA_HSYNC); end
    checks++; if (oVGA_VSYNC !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b required 1", oVGA_VSYNC); end
    checks++; if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b required 000", {oVGA_RED, oVGA_GREEN, oVGA_BLUE}); end
    checks++; if (oReadAddress !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h required 0000", oReadAddress); end
    checks++; if (oFrameStart !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b required 0", oFrameStart); end
    Reset = 1'b1;
    checks++; if (oFrameStart !== 1'b0) begin errors++; $display("FAIL fs_clk0: got %b required 0", oFrameStart); end
    tick;
    checks++; if (oFrameStart !== 1'b1) begin errors++; $display("FAIL fs_clk1: got %b required 1", oFrameStart); end
    tick;
    checks++; if (oFrameStart !== 1'b0) begin errors++; $display("FAIL fs_clk2: got %b required 0", oFrameStart); end
  endtask

  task test_hsync;
    int falls[3];
    int nFalls, firstRise, fsCount, fsAt;
    logic prevHs;
    falls = '{-1, -1, -1};
    nFalls = 0; firstRise = -1; fsCount = 0; fsAt = -1; prevHs = 1'b1;
    Reset = 1'b0;
    repeat (2) tick;
    Reset = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      if (n > 0) tick;
      if (prevHs === 1'b1 && oVGA_HSYNC === 1'b0) begin
        if (nFalls < 3) falls[nFalls] = n;
        nFalls++;
      end
      if (prevHs === 1'b0 && oVGA_HSYNC === 1'b1 && firstRise < 0) firstRise = n;
      prevHs = oVGA_HSYNC;
      if (oFrameStart === 1'b1) begin fsCount++; if (fsAt < 0) fsAt = n; end
      if (n == 3) begin
        checks++; if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} !== 3'b101) begin errors++; $display("FAIL rgb_col0_row0: got %b required 101", {oVGA_RED, oVGA_GREEN, oVGA_BLUE}); end
      end
      if (n == 1282) begin
        checks++; if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} !== 3'b101) begin errors++; $display("FAIL rgb_col639: got %b required 101", {oVGA_RED, oVGA_GREEN, oVGA_BLUE}); end
      end
      if (n == 1283) begin
        checks++; if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} !== 3'b000) begin errors++; $display("FAIL rgb_col640: got %b required 000", {oVGA_RED, oVGA_GREEN, oVGA_BLUE}); end
      end
    end
    checks++; if (nFalls != 3) begin errors++; $display("FAIL hs_fall_count: got %0d required 3", nFalls); end
    checks++; if (falls[0] != 1315) begin errors++; $display("FAIL hs_first_fall: got %0d required 1315", falls[0]); end
    checks++; if (falls[1] - falls[0] != 1600) begin errors++; $display("FAIL hs_period1: got %0d required 1600", falls[1] - falls[0]); end
    checks++; if (falls[2] - falls[1] != 1600) begin errors++; $display("FAIL hs_period2: got %0d required 1600", falls[2] - falls[1]); end
    checks++; if (firstRise - falls[0] != 192) begin errors++; $display("FAIL hs_low_width: got %0d required 192", firstRise - falls[0]); end
    checks++; if (fsCount != 1 || fsAt != 1) begin errors++; $display("FAIL fs_single: got count %0d at %0d required 1 at 1", fsCount, fsAt); end
  endtask

  typedef struct {
    int          row;
    int          col;
    logic [15:0] addr;
    logic [2:0]  rgb;
  } vec_t;

  task test_window_border;
    vec_t vecs[12];
    vecs = '{
      '{112, 192, 16'h0000, 3'b000},
      '{367, 447, 16'hFFFF, 3'b111},
      '{200, 300, 16'h586C, 3'b000},
      '{113, 193, 16'h0101, 3'b110},
      '{112, 191, 16'h00FF, 3'b101},
      '{200, 448, 16'h5800, 3'b101},
      '{  0,   0, 16'h9040, 3'b101},
      '{  0, 640, 16'h90C0, 3'b000},
      '{480, 100, 16'h70A4, 3'b000},
      '{367, 448, 16'hFF00, 3'b101},
      '{368, 300, 16'h006C, 3'b101},
      '{479, 639, 16'h6FBF, 3'b101}
    };
    foreach (vecs[i]) begin
      jumpTo(vecs[i].row, vecs[i].col);
      tick;
      checks++;
      if (oReadAddress !== vecs[i].addr) begin
        errors++;
        $display("FAIL win_addr(%0d,%0d): got %h required %h", vecs[i].row, vecs[i].col, oReadAddress, vecs[i].addr);
      end
      tick;
      tick;
      checks++;
      if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} !== vecs[i].rgb) begin
        errors++;
        $display("FAIL win_rgb_a(%0d,%0d): got %b required %b", vecs[i].row, vecs[i].col, {oVGA_RED, oVGA_GREEN, oVGA_BLUE}, vecs[i].rgb);
      end
      tick;
      checks++;
      if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} !== vecs[i].rgb) begin
        errors++;
        $display("FAIL win_rgb_b(%0d,%0d): got %b required %b", vecs[i].row, vecs[i].col, {oVGA_RED, oVGA_GREEN, oVGA_BLUE}, vecs[i].rgb);
      end
    end
  endtask

  task test_vsync;
    int vsFall, vsRise, hsFall, vsFalls;
    logic prevVs, prevHs;
    vsFall = -1; vsRise = -1; hsFall = -1; vsFalls = 0;
    jumpTo(489, 790);
    prevVs = oVGA_VSYNC;
    prevHs = oVGA_HSYNC;
    for (int k = 1; k <= 4700; k++) begin
      tick;
      if (prevVs === 1'b1 && oVGA_VSYNC === 1'b0) begin vsFalls++; if (vsFall < 0) vsFall = k; end
      if (prevVs === 1'b0 && oVGA_VSYNC === 1'b1 && vsRise < 0) vsRise = k;
      if (prevHs === 1'b1 && oVGA_HSYNC === 1'b0 && vsFall >= 0 && hsFall < 0) hsFall = k;
      prevVs = oVGA_VSYNC;
      prevHs = oVGA_HSYNC;
    end
    checks++; if (vsFalls != 1 || vsFall != 23) begin errors++; $display("FAIL vs_fall: got %0d falls, first at %0d, required 1 at 23", vsFalls, vsFall); end
    checks++; if (vsRise - vsFall != 3200) begin errors++; $display("FAIL vs_low_width: got %0d required 3200", vsRise - vsFall); end
    checks++; if (hsFall - vsFall != 1312) begin errors++; $display("FAIL vs_line_align: got %0d required 1312", hsFall - vsFall); end
  endtask

  task test_frame_wrap;
    int fsCount, fsAt;
    fsCount = 0; fsAt = -1;
    jumpTo(524, 795);
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (oFrameStart === 1'b1) begin fsCount++; if (fsAt < 0) fsAt = k; end
    end
    checks++; if (fsCount != 1 || fsAt != 11) begin errors++; $display("FAIL frame_wrap_fs: got count %0d at %0d required 1 at 11", fsCount, fsAt); end
  endtask

  task test_mid_reset;
    int hsFall, hsRise, fsCount, fsAt;
    logic prevHs;
    hsFall = -1; hsRise = -1; fsCount = 0; fsAt = -1; prevHs = 1'b1;
    jumpTo(300, 400);
    repeat (3) tick;
    checks++; if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} !== 3'b001) begin errors++; $display("FAIL mid_pre_rgb: got %b required 001", {oVGA_RED, oVGA_GREEN, oVGA_BLUE}); end
    Reset = 1'b0;
    tick;
    checks++; if (oVGA_HSYNC !== 1'b1 || oVGA_VSYNC !== 1'b1) begin errors++; $display("FAIL mid_sync: got hs=%b vs=%b required 1 1", oVGA_HSYNC, oVGA_VSYNC); end
    checks++; if ({oVGA_RED, oVGA_GREEN, oVGA_BLUE} !== 3'b000) begin errors++; $display("FAIL mid_rgb: got %b required 000", {oVGA_RED, oVGA_GREEN, oVGA_BLUE}); end
    checks++; if (oReadAddress !== 16'h0000) begin errors++; $display("FAIL mid_addr: got %h required 0000", oReadAddress); end
    checks++; if (oFrameStart !== 1'b0) begin errors++; $display("FAIL mid_fs: got %b required 0", oFrameStart); end
    Reset = 1'b1;
    for (int n = 0; n < 1700; n++) begin
      if (n > 0) tick;
      if (oFrameStart === 1'b1) begin fsCount++; if (fsAt < 0) fsAt = n; end
      if (prevHs === 1'b1 && oVGA_HSYNC === 1'b0 && hsFall < 0) hsFall = n;
      if (prevHs === 1'b0 && oVGA_HSYNC === 1'b1 && hsRise < 0) hsRise = n;
      prevHs = oVGA_HSYNC;
    end
    checks++; if (fsCount != 1 || fsAt != 1) begin errors++; $display("FAIL mid_fs_restart: got count %0d at %0d required 1 at 1", fsCount, fsAt); end
    checks++; if (hsFall != 1315) begin errors++; $display("FAIL mid_hs_fall: got %0d required 1315", hsFall); end
    checks++; if (hsRise - hsFall != 192) begin errors++; $display("FAIL mid_hs_width: got %0d required 192", hsRise - hsFall); end
  endtask

  initial begin
    Reset = 1'b0;
    jRow = '0;
    jCol = '0;
    test_reset;
    test_hsync;
    test_window_border;
    test_vsync;
    test_frame_wrap;
    test_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
